// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and helpers for the writeback stage of the MIPS pipeline.
//   WB_REGWRITE / WB_MEMTOREG : bit positions inside the memory-stage wb bus
//   MASK_*                    : the four legal load-width masks
//   REG_ZERO                  : the hardwired-zero register address
//   ld_width_e / decode_mask  : classify a load mask, illegal masks map to word
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] MASK_T = 32'h00FF_FFFF;
    localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        LW_BYTE,
        LW_HALF,
        LW_TRI,
        LW_WORD
    } ld_width_e;

    // Anything that is not one of the three narrow masks is a full word load.
    function automatic ld_width_e decode_mask(input logic [31:0] mask);
        case (mask)
            MASK_B:  return LW_BYTE;
            MASK_H:  return LW_HALF;
            MASK_T:  return LW_TRI;
            default: return LW_WORD;
        endcase
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// Bus between the memory stage / decode / debug unit and the writeback stage.
//   master : drives memory-stage results, read addresses, debug address
//   slave  : the writeback stage; returns read data, write bus, debug data,
//            retired-instruction count
// -----------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DW   = 32,
    parameter int CNTW = 32
);
    // memory stage -> writeback
    logic [1:0]      wbi;
    logic [DW-1:0]   datafrommem;
    logic [DW-1:0]   datafromimm;
    logic [4:0]      regaddr;
    logic [DW-1:0]   datamask;
    logic            load_signed;
    logic            nop;
    // decode read ports
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    // forwarding bus
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [DW-1:0]   wb_data;
    // debug unit
    logic [4:0]      dbg_addr;
    logic [DW-1:0]   dbg_data;
    logic [CNTW-1:0] retired;

    modport master (
        output wbi, datafrommem, datafromimm, regaddr, datamask, load_signed, nop,
        output rs_addr, rt_addr, dbg_addr,
        input  rs_data, rt_data, wb_we, wb_addr, wb_data, dbg_data, retired
    );

    modport slave (
        input  wbi, datafrommem, datafromimm, regaddr, datamask, load_signed, nop,
        input  rs_addr, rt_addr, dbg_addr,
        output rs_data, rt_data, wb_we, wb_addr, wb_data, dbg_data, retired
    );

endinterface

// File: rtl/wb_regfile_load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
// Combinational load-data formatting: mask the raw RAM word to the load width
// and optionally sign-extend from the top bit of that width.
//   data_i   : raw RAM word
//   mask_i   : load width mask (illegal values behave as the full mask)
//   signed_i : 1 sign-extends the masked value
//   data_o   : formatted load value
// -----------------------------------------------------------------------------
module load_formatter
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] data_i,
    input  logic [DW-1:0] mask_i,
    input  logic          signed_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] eff_mask;
    logic          sign_bit;
    logic [DW-1:0] masked;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        eff_mask = MASK_W;
        sign_bit = 1'b0;
        case (decode_mask(mask_i))
            LW_BYTE: begin eff_mask = MASK_B; sign_bit = data_i[7];  end
            LW_HALF: begin eff_mask = MASK_H; sign_bit = data_i[15]; end
            LW_TRI:  begin eff_mask = MASK_T; sign_bit = data_i[23]; end
            default: begin eff_mask = MASK_W; sign_bit = 1'b0;       end
        endcase
        masked = data_i & eff_mask;
        // Sign extension fills exactly the bits the mask cleared.
        data_o = (signed_i && sign_bit) ? (masked | ~eff_mask) : masked;
    end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage: selects/format the writeback value, commits it to the
// register file (r0 hardwired to zero), serves two bypassed decode read ports,
// a registered debug read port and a retired-instruction counter.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wb_regfile_if.slave (memory-stage inputs, read ports, write bus,
//           debug port, retired count)
// -----------------------------------------------------------------------------
module wb_regfile
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int CNTW  = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    logic [DW-1:0]   regs_q [NREGS];
    logic [DW-1:0]   dbg_q;
    logic [CNTW-1:0] retired_q;
    logic [CNTW-1:0] retired_d;

    logic [DW-1:0]   ld_fmt;
    logic [DW-1:0]   wb_data;
    logic            wb_we;

    load_formatter #(.DW(DW)) u_load_formatter (
        .data_i   (bus.datafrommem),
        .mask_i   (bus.datamask),
        .signed_i (bus.load_signed),
        .data_o   (ld_fmt)
    );

    assign wb_data = bus.wbi[WB_MEMTOREG] ? ld_fmt : bus.datafromimm;
    // Excluding r0 here means regs_q[0] is never written and stays at its
    // reset value of zero, so reads need no special case for address 0.
    assign wb_we   = bus.wbi[WB_REGWRITE] & ~bus.nop & (bus.regaddr != REG_ZERO);

    assign bus.wb_we   = wb_we;
    assign bus.wb_addr = bus.regaddr;
    assign bus.wb_data = wb_data;

    // Write-through bypass: decode sees the value being committed this cycle.
    assign bus.rs_data = (wb_we && (bus.regaddr == bus.rs_addr)) ? wb_data : regs_q[bus.rs_addr];
    assign bus.rt_data = (wb_we && (bus.regaddr == bus.rt_addr)) ? wb_data : regs_q[bus.rt_addr];

    assign bus.dbg_data = dbg_q;
    assign bus.retired  = retired_q;

    always_comb begin
        retired_d = retired_q;
        if (!bus.nop) begin
            retired_d = retired_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register array is reset on purpose: architectural state
            // must read zero after reset, which costs a reset on every flop
            // instead of letting this map to a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            dbg_q     <= '0;
            retired_q <= '0;
        end else begin
            if (wb_we) begin
                regs_q[bus.regaddr] <= wb_data;
            end
            // NOTE: non-blocking assignment samples regs_q before this edge's
            // write, so a same-cycle debug read of the written register returns
            // the old value and the new one appears a cycle later.
            dbg_q     <= regs_q[bus.dbg_addr];
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage of the 5-stage MIPS pipeline, directly downstream of the memory stage.
- Consumes the memory stage's registered outputs: wb control, load data, ALU/address result, destination register, byte mask and nop flag.
- Selects and formats the writeback value and commits it to the 32x32 register file, which the decode stage reads.
- Exports the write bus for forwarding and a retired-instruction counter plus a debug read port for the debug unit.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- DW, 32, datapath width.
- CNTW, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wbi  in  2  from memory stage: wbi[0] RegWrite, wbi[1] MemToReg (1 selects load data).
- datafrommem  in  DW  raw RAM word from memory stage.
- datafromimm  in  DW  ALU result / address from memory stage.
- regaddr  in  5  destination register.
- datamask  in  DW  load width mask: 0xFF, 0xFFFF, 0xFFFFFF or 0xFFFFFFFF.
- load_signed  in  1  1 sign-extends masked load data.
- nop  in  1  bubble flag; 1 means the slot carries no instruction.
- rs_addr  in  5  decode read port A address.
- rt_addr  in  5  decode read port B address.
- rs_data  out  DW  read port A data.
- rt_data  out  DW  read port B data.
- wb_we  out  1  effective write enable, for the forwarding unit.
- wb_addr  out  5  effective write address.
- wb_data  out  DW  formatted writeback value.
- dbg_addr  in  5  debug read address.
- dbg_data  out  DW  debug read data, registered.
- retired  out  CNTW  count of non-nop instructions retired.

Behaviour:
- Load formatting: ld = datafrommem & datamask.
  - If load_signed, bits above the mask's top set bit are replaced by that bit: bit 7, 15 or 23; no change for the full mask.
  - A mask not among the four legal values is treated as the full mask.
- wb_data = wbi[1] ? formatted ld : datafromimm (combinational).
- wb_we = wbi[0] & ~nop & (regaddr != 0). wb_addr = regaddr. All combinational.
- Register write on the rising clk edge when wb_we is 1: reg[regaddr] <= wb_data.
- reg[0] is never written and always reads 0.
- Read ports are combinational with write-through bypass:
  - If wb_we is 1 and wb_addr == rs_addr (nonzero), rs_data = wb_data; otherwise rs_data = reg[rs_addr].
  - rt_data uses the same rule with rt_addr.
  - Effect: an instruction in decode sees a value being written in the same cycle.
- Debug port: dbg_data <= reg[dbg_addr] every edge, 1-cycle latency, no bypass.
- Retired counter:
  - Increments by 1 on each edge with nop == 0, independent of RegWrite, so stores and branches count.
  - Wraps from all-ones to 0.
- Reset is asynchronous and clears all registers, dbg_data and retired to 0. Combinational outputs follow the cleared state.
  - Reset asserted mid-operation: the pending write is discarded, and the first edge after release behaves normally.
- Simultaneous write and debug read of the same register: dbg_data gets the old value and shows the new value one cycle later.
- Width rules: all data paths are DW bits; the counter is CNTW bits, unsigned.

Decomposition:
- Shared package (mips_pkg): WB_REGWRITE=0 and WB_MEMTOREG=1 bit indices, the four MASK_* constants, REG_ZERO=5'd0.
- One sub-module, load_formatter: combinational mask and sign extension. The parent module holds the register array, bypass, debug register and counter.

Test Plan:
- Reset, then read r1..r31 via rs/rt/dbg -> all 0; retired=0.
- wbi=01, nop=0, regaddr=5, datafromimm=0x12345678, rs_addr=5 in the same cycle -> rs_data=0x12345678 via bypass; after the edge, reg5 holds it; retired=1.
- wbi=11, datafrommem=0xDEADBEEF, datamask=0xFF: load_signed=1 -> wb_data=0xFFFFFFEF; load_signed=0 -> 0x000000EF. Mask 0xFFFF, signed -> 0xFFFFBEEF.
- Write to regaddr=0 with wbi=01, value 0xFFFFFFFF -> wb_we=0; rs_addr=0 reads 0; retired still increments.
- nop=1 with wbi=01, regaddr=7, value 0xA5 -> reg7 unchanged and retired unchanged.
- Counter preloaded near wrap (CNTW=4 build, 15 non-nop instructions then one more) -> retired goes 15 then 0.
- Assert reset between clock edges while wb_we=1 -> reg unchanged and outputs clear immediately, without waiting for a clock edge.
